// File: rtl/alu_seq_unit.sv
// Sequential ALU engine with valid/ready handshakes on both sides.
// Single-cycle ops register their result on the accept edge; divide runs a WIDTH-step restoring loop.
module alu_seq_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [WIDTH-1:0] out_rem,
    output logic [3:0]       out_flag
);

    localparam int SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_MUL  = 4'h2;
    localparam logic [3:0] OP_DIV  = 4'h3;
    localparam logic [3:0] OP_SHL  = 4'h4;
    localparam logic [3:0] OP_SHR  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_XNOR = 4'h9;
    localparam logic [3:0] OP_NAND = 4'hA;
    localparam logic [3:0] OP_NOR  = 4'hB;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_result;
    logic [WIDTH-1:0] r_out_rem;
    logic [3:0]       r_out_flag;

    // Divider: r_quo starts as the dividend and shifts quotient bits in from the right.
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_part_rem;
    logic [WIDTH-1:0] r_divisor;
    logic [CW-1:0]    r_cnt;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [2*WIDTH-1:0] w_prod;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH-1:0]   w_and;
    logic [WIDTH-1:0]   w_or;
    logic [WIDTH-1:0]   w_xor;
    logic [WIDTH-1:0]   w_xnor;
    logic [WIDTH-1:0]   w_nand;
    logic [WIDTH-1:0]   w_nor;
    logic               w_add_ovf;
    logic               w_sub_ovf;
    logic               w_b_zero;
    logic               w_start_div;

    logic [WIDTH-1:0] w_res;
    logic [WIDTH-1:0] w_rem;
    logic             w_carry;
    logic             w_ovf;
    logic             w_err;
    logic [3:0]       w_flag;

    logic [WIDTH:0]   w_step_part;
    logic [WIDTH:0]   w_step_trial;
    logic             w_step_ge;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_quo;
    logic             w_div_last;

    assign w_sum     = {1'b0, in_a} + {1'b0, in_b};
    assign w_diff    = {1'b0, in_a} - {1'b0, in_b};
    assign w_prod    = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
    assign w_shamt   = in_b[SHW-1:0];
    assign w_add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
    assign w_sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
    assign w_b_zero  = (in_b == '0);
    assign w_start_div = (in_sel == OP_DIV) && !w_b_zero;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign w_and[gi]  = in_a[gi] & in_b[gi];
            assign w_or[gi]   = in_a[gi] | in_b[gi];
            assign w_xor[gi]  = in_a[gi] ^ in_b[gi];
            assign w_xnor[gi] = ~(in_a[gi] ^ in_b[gi]);
            assign w_nand[gi] = ~(in_a[gi] & in_b[gi]);
            assign w_nor[gi]  = ~(in_a[gi] | in_b[gi]);
        end
    endgenerate

    always_comb begin
        w_res   = '0;
        w_rem   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        case (in_sel)
            OP_ADD: begin
                w_res   = w_sum[WIDTH-1:0];
                w_carry = w_sum[WIDTH];
                w_ovf   = w_add_ovf;
            end
            OP_SUB: begin
                w_res   = w_diff[WIDTH-1:0];
                w_carry = w_diff[WIDTH];
                w_ovf   = w_sub_ovf;
            end
            OP_MUL: begin
                w_res   = w_prod[WIDTH-1:0];
                w_carry = (w_prod[2*WIDTH-1:WIDTH] != '0);
            end
            OP_DIV: begin
                // Only the divide-by-zero case completes here; real divides go through S_DIV.
                if (w_b_zero) begin
                    w_res = '1;
                    w_rem = in_a;
                    w_err = 1'b1;
                end
            end
            OP_SHL:  w_res = in_a << w_shamt;
            OP_SHR:  w_res = in_a >> w_shamt;
            OP_AND:  w_res = w_and;
            OP_OR:   w_res = w_or;
            OP_XOR:  w_res = w_xor;
            OP_XNOR: w_res = w_xnor;
            OP_NAND: w_res = w_nand;
            OP_NOR:  w_res = w_nor;
            default: w_err = 1'b1;
        endcase
        w_flag = {w_err, w_ovf, w_carry, (w_res == '0)};
    end

    // Partial remainder stays below the divisor, so one extra bit is enough for the trial subtract.
    assign w_step_part  = {r_part_rem, r_quo[WIDTH-1]};
    assign w_step_trial = w_step_part - {1'b0, r_divisor};
    assign w_step_ge    = !w_step_trial[WIDTH];
    assign w_step_rem   = w_step_ge ? w_step_trial[WIDTH-1:0] : w_step_part[WIDTH-1:0];
    assign w_step_quo   = {r_quo[WIDTH-2:0], w_step_ge};
    assign w_div_last   = (r_cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_rem    <= '0;
            r_out_flag   <= '0;
            r_quo        <= '0;
            r_part_rem   <= '0;
            r_divisor    <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        if (w_start_div) begin
                            r_quo      <= in_a;
                            r_divisor  <= in_b;
                            r_part_rem <= '0;
                            r_cnt      <= '0;
                            r_state    <= S_DIV;
                        end else begin
                            r_out_result <= w_res;
                            r_out_rem    <= w_rem;
                            r_out_flag   <= w_flag;
                            r_out_valid  <= 1'b1;
                            r_state      <= S_HOLD;
                        end
                    end
                end
                S_DIV: begin
                    r_quo      <= w_step_quo;
                    r_part_rem <= w_step_rem;
                    r_cnt      <= r_cnt + CW'(1);
                    if (w_div_last) begin
                        r_out_result <= w_step_quo;
                        r_out_rem    <= w_step_rem;
                        r_out_flag   <= {3'b000, (w_step_quo == '0)};
                        r_out_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = (r_state == S_IDLE);
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_rem    = r_out_rem;
    assign out_flag   = r_out_flag;

endmodule

// File: doc/alu_seq_unit.md
Name: alu_seq_unit

Overview:
- Sequential request/response ALU engine that executes the team's ALU operation set behind valid/ready handshakes.
- Holds each result until the consumer accepts it.
- Adds a multi-cycle restoring divider, a remainder output and defined flags.
- Sits between a command source (CPU sequencer or bench driver) and any consumer needing registered, flow-controlled ALU results.

Parameters:
WIDTH, 8, operand/result width in bits; divider iteration count equals WIDTH.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request valid
in_ready  output  1  unit can accept request
in_a  input  WIDTH  operand A
in_b  input  WIDTH  operand B
in_sel  input  4  operation select
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_rem  output  WIDTH  division remainder, 0 for non-divide ops
out_flag  output  4  {err, ovf, carry, zero} = flag[3:0]

Behaviour:
- Encoding:
  - 0 add, 1 sub (A-B), 2 mul (low WIDTH bits), 3 div (A/B unsigned).
  - 4 shl (A << B[2:0]), 5 shr logical (A >> B[2:0]).
  - 6 and, 7 or, 8 xor, 9 xnor, A nand, B nor.
  - C–F illegal: result 0, err=1.
- Reset (asynchronous, immediate):
  - State=IDLE.
  - out_valid=0, out_result=0, out_rem=0, out_flag=0.
  - Operand/divider registers cleared.
  - Reset mid-divide abandons the operation with no output.
- FSM states: IDLE, DIV, HOLD.
- in_ready = (state==IDLE). Requests are ignored while rst is high.
- Accept on rising edge with in_valid && in_ready; in_a, in_b, in_sel are latched.
- Single-cycle ops: on the accept edge N the result and flags are registered, out_valid=1 from edge N, state→HOLD.
  - Latency: result visible in the cycle after acceptance.
- Div, B≠0: accept edge N → DIV. One restoring step per edge, WIDTH steps total. At edge N+WIDTH quotient/remainder are registered, out_valid=1, state→HOLD.
- Div, B=0: handled as single-cycle. Result all-ones, rem=A, err=1.
- HOLD:
  - out_result, out_rem, out_flag and out_valid stay stable until out_valid && out_ready at an edge.
  - That edge clears out_valid and moves to IDLE. No request is accepted on that same edge.
  - Minimum throughput: one op per 2 cycles.
- in_valid during DIV/HOLD: no effect. Requester must hold its request.
- out_ready while not out_valid: ignored.
- Flags:
  - zero = (result==0), all ops, including div quotient.
  - carry: add carry-out; sub borrow (A<B unsigned); mul (product[2W-1:W]≠0); else 0.
  - ovf: signed two's-complement overflow for add/sub; else 0.
  - err: div-by-zero or illegal sel; else 0.
- Arithmetic is unsigned modulo 2^WIDTH. Results wrap, no saturation.

Test Plan:
1. Add: A=01, B=02, sel=0, out_ready=1. → out_result=03, flag=0000, out_valid exactly 1 cycle after accept, in_ready back high 1 cycle later.
2. Add wrap: A=80, B=80, sel=0 → result 00, flag=0111. Sub: A=71, B=06, sel=1 → result 6B, flag=0000. Sub: A=01, B=02 → FF, carry=1.
3. Mul: A=20, B=10, sel=2 → result 00, flag=0011. Shl: A=71, B=06 → 40. Nor: A=71, B=06 → 88.
4. Div: A=71, B=06, sel=3 → result 12, rem 05, out_valid exactly 8 cycles after accept, in_ready=0 throughout. Div: A=01, B=04 → 00, rem 01, flag=0001. Div-by-zero: A=05, B=00 → FF, rem 05, flag=1000, latency 1. Sel=E → 00, flag=1001.
5. Backpressure: hold out_ready=0 for 5 cycles after a result → outputs bit-stable, in_ready=0, a new in_valid pulse is not accepted. Raising out_ready → handshake, IDLE next cycle.
6. Reset mid-divide: assert rst 3 cycles into DIV, asynchronously between edges → out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and a new add (01+02) completes normally.
